sram_port_master: RTL and testbench



---
 rtl/sram_port_master.sv | 112 +++++++++++
 tb/tb_sram_port_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_master.sv
// Initiator for the single-port synchronous SRAM: valid/ready request and response channels,
// registered RAM control pins, and the master side of the shared tristate data bus.
module sram_port_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
    // a producer holds valid and its payload stable until that edge.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Only the write cycle drives the bus; mem_we is high in exactly that state.
    assign mem_data = (state == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mem_addr  <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        mem_cs    <= 1'b1;
                        if (req_we) begin
                            mem_we <= 1'b1;
                            state  <= WR;
                        end else begin
                            state  <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    mem_cs    <= 1'b0;
                    mem_we    <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                RD_ADDR: begin
                    mem_oe <= 1'b1;
                    state  <= RD_DATA;
                end
                RD_DATA: begin
                    // RSP keeps the bus idle for one cycle so a following write cannot collide
                    // with the RAM still releasing its output drivers.
                    rsp_rdata <= mem_data;
                    rsp_valid <= 1'b1;
                    mem_cs    <= 1'b0;
                    mem_oe    <= 1'b0;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    mem_cs    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_oe    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master: behavioural SRAM on the shared bus, table of request vectors,
// scoreboard queue for read responses, and hand-written sequences for timing corner cases.
module tb_sram_port_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
    logic [3:0]  mem_addr;
    wire  [31:0] mem_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];

    // Behavioural RAM plus a probe driver that lets the bench test that the master has released the bus.
    logic [31:0] ram [16];
    logic [31:0] ram_q = '0;
    logic        probe_en = 1'b0;
    logic [31:0] probe_val = '0;

    assign mem_data = probe_en ? probe_val : (mem_oe ? ram_q : 32'bz);

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_data;
            else        ram_q <= ram[mem_addr];
        end
    end

    sram_port_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    // Clock and cycle counter
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for acceptance, return 1 unit after the accepting edge.
    task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, output int acc_cyc);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            to_drive();
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(n), 32'd0);
            req_valid = 1'b0;
            acc_cyc = cyc;
        end else begin
            if (!we) exp_q.push_back(exp_rd);
            to_drive();
            acc_cyc   = cyc;
            req_valid = 1'b0;
        end
    endtask

    // Scoreboard: every completed response handshake pops one expected read value.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", rsp_rdata, 32'hxxxx_xxxx);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Bus checker: no read-enable with write-enable, and an idle (cs=0) cycle between read data and a write.
    logic oe_pending = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            oe_pending <= 1'b0;
        end else begin
            if (mem_we) begin
                check("turnaround_gap", {31'd0, oe_pending}, 32'd0);
                check("we_with_oe", {31'd0, mem_oe}, 32'd0);
            end
            if (mem_oe) begin
                check("bus_x", {31'd0, ^mem_data}, {31'd0, ^ram_q});
                oe_pending <= 1'b1;
            end else if (!mem_cs) begin
                oe_pending <= 1'b0;
            end
        end
    end

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int acc, prev_acc, rd_acc;
        logic prev_we;
        int n;

        // Table: 16 back-to-back writes, 16 readbacks, then a few mixed patterns.
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1'b1, 4'(i), 32'(i) * 32'h0101_0101, 32'd0});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1'b0, 4'(i), 32'd0, 32'(i) * 32'h0101_0101});
        tbl.push_back('{1'b1, 4'h9, 32'h5A5A_A5A5, 32'd0});
        tbl.push_back('{1'b0, 4'h9, 32'd0, 32'h5A5A_A5A5});
        tbl.push_back('{1'b0, 4'h0, 32'd0, 32'h0000_0000});
        tbl.push_back('{1'b1, 4'hF, 32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{1'b0, 4'hF, 32'd0, 32'hFFFF_FFFF});

        // Reset values
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
        check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        to_drive();

        // Single write, then read with latency checks
        send(1'b1, 4'h3, 32'hDEAD_BEEF, 32'd0, acc);
        @(negedge clk);
        check("wr_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'b110);
        check("wr_addr", {28'd0, mem_addr}, 32'h3);
        check("wr_bus", mem_data, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_end_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'b000);
        to_drive();
        send(1'b0, 4'h3, 32'd0, 32'hDEAD_BEEF, acc);
        @(negedge clk);
        check("rd_addr_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'b100);
        check("rd_e0_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("rd_data_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'b101);
        check("rd_e1_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("rd_e2_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_e2_data", rsp_rdata, 32'hDEAD_BEEF);
        check("rsp_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'b000);
        to_drive();
        @(negedge clk);
        check("rd_idle", {30'd0, busy, req_ready}, 32'b01);
        to_drive();

        // Asynchronous reset while in WR
        send(1'b1, 4'hF, 32'hFEED_FACE, 32'd0, acc);
        check("pre_rst_we", {30'd0, mem_cs, mem_we}, 32'b11);
        check("pre_rst_bus", mem_data, 32'hFEED_FACE);
        #2 rst = 1'b1;
        #1;
        check("arst_ctl", {29'd0, mem_cs, mem_we, mem_oe}, 32'b000);
        check("arst_flags", {29'd0, req_ready, busy, rsp_valid}, 32'b100);
        check("arst_addr", {28'd0, mem_addr}, 32'd0);
        check("arst_rdata", rsp_rdata, 32'd0);
        probe_en = 1'b1;
        probe_val = 32'h0000_0000;
        #1 check("arst_bus_rel0", mem_data, 32'h0000_0000);
        probe_val = 32'hFFFF_FFFF;
        #1 check("arst_bus_rel1", mem_data, 32'hFFFF_FFFF);
        probe_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {30'd0, req_ready, busy}, 32'b10);
        to_drive();

        // Table-driven vectors with acceptance spacing checks
        prev_acc = 0;
        prev_we = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, acc);
            if (i > 0) check($sformatf("gap_%0d", i), 32'(acc - prev_acc), prev_we ? 32'd2 : 32'd4);
            prev_acc = acc;
            prev_we = tbl[i].we;
        end
        repeat (4) to_drive();

        // Response backpressure with a spurious request that must be ignored
        rsp_ready = 1'b0;
        send(1'b0, 4'h7, 32'd0, 32'h0707_0707, acc);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 4'h7;
        req_wdata = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rdata", rsp_rdata, 32'h0707_0707);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_cs", {31'd0, mem_cs}, 32'd0);
        end
        to_drive();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        to_drive();
        @(negedge clk);
        check("bp_release", {29'd0, req_ready, busy, rsp_valid}, 32'b100);
        to_drive();
        send(1'b0, 4'h7, 32'd0, 32'h0707_0707, acc);

        // Read immediately followed by a write
        send(1'b0, 4'h1, 32'd0, 32'h0101_0101, rd_acc);
        send(1'b1, 4'h2, 32'h1234_5678, 32'd0, acc);
        check("rd_to_wr_gap", 32'(acc - rd_acc), 32'd4);
        send(1'b0, 4'h2, 32'd0, 32'h1234_5678, acc);

        // Inputs changed after acceptance must not affect the transaction
        send(1'b1, 4'h5, 32'hAAAA_5555, 32'd0, acc);
        req_addr = 4'h6;
        req_wdata = 32'h0;
        req_we = 1'b0;
        @(negedge clk);
        check("stab_addr", {28'd0, mem_addr}, 32'h5);
        check("stab_bus", mem_data, 32'hAAAA_5555);
        to_drive();
        send(1'b0, 4'h5, 32'd0, 32'hAAAA_5555, acc);
        send(1'b0, 4'h6, 32'd0, 32'h0606_0606, acc);

        // Drain the scoreboard
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            to_drive();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
